// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I core types and constants
package rv32i_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0: the canonical bubble loaded into decode
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with stall, flush and bubble insertion
module if_id_reg
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            valid
);

  // Flush beats stall; otherwise a stall freezes the register and an idle
  // cycle without a delivered instruction turns into a NOP bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush || (!stall && !load)) begin
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (!stall) begin
      instr    <= load_instr;
      pc       <= load_pc;
      pc_plus4 <= load_pc + 32'd4;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch stage (FETCH_PERF_EN adds FetchCount/KillCount)
module fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Stall_f,
  input  logic            Stall_d,
  input  logic            Flush_d,
  input  logic            PCSrc_e,
  input  logic [XLEN-1:0] PCTarget_e,
  output logic            IMemReq_f,
  output logic [XLEN-1:0] IMemAddr_f,
  input  logic            IMemGnt_f,
  input  logic            IMemRValid,
  input  logic [XLEN-1:0] IMemRData,
  output logic [XLEN-1:0] Instr_d,
  output logic [XLEN-1:0] PC_d,
  output logic [XLEN-1:0] PCPlus4_d,
  output logic            Valid_d
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0] FetchCount,
  output logic [XLEN-1:0] KillCount
`endif
);

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] inflight_pc;
  logic            kill, kill_n;
  logic            hold_valid;
  logic [XLEN-1:0] hold_instr;
  logic [XLEN-1:0] hold_pc;

  logic            req;
  logic            fire;
  logic            take;
  logic            to_hold;
  logic            from_hold;
  logic            outstanding;
  logic            load;
  logic [XLEN-1:0] load_instr;
  logic [XLEN-1:0] load_pc;

  // Next-state and request logic; a redirect overrides every other decision.
  always_comb begin
    state_n     = state;
    kill_n      = kill;
    req         = 1'b0;
    take        = 1'b0;
    to_hold     = 1'b0;
    from_hold   = 1'b0;
    outstanding = 1'b0;
    case (state)
      IDLE: state_n = REQ;
      REQ: begin
        req = !Stall_f;
        if (req && IMemGnt_f) state_n = WAIT;
      end
      WAIT: begin
        if (IMemRValid) begin
          if (kill) begin
            kill_n  = 1'b0;
            state_n = REQ;
          end else if (!Stall_d) begin
            take    = 1'b1;
            req     = !Stall_f;
            state_n = (req && IMemGnt_f) ? WAIT : REQ;
          end else begin
            to_hold = 1'b1;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (!Stall_d) begin
          from_hold = 1'b1;
          state_n   = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
    if (PCSrc_e) begin
      // A grant without a response is still in flight and must be killed.
      outstanding = (state == WAIT) && !IMemRValid;
      req         = 1'b0;
      take        = 1'b0;
      to_hold     = 1'b0;
      from_hold   = 1'b0;
      kill_n      = outstanding;
      state_n     = outstanding ? WAIT : REQ;
    end
  end

  assign IMemReq_f  = req;
  assign IMemAddr_f = pc_f;
  assign fire       = req && IMemGnt_f;

  assign load       = take || (from_hold && hold_valid);
  assign load_instr = from_hold ? hold_instr : IMemRData;
  assign load_pc    = from_hold ? hold_pc : inflight_pc;

  // FSM state, fetch PC, in-flight PC and kill flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc_f        <= RESET_PC;
      inflight_pc <= '0;
      kill        <= 1'b0;
    end else begin
      state <= state_n;
      kill  <= kill_n;
      if (fire) inflight_pc <= pc_f;
      if (PCSrc_e) pc_f <= PCTarget_e;
      else if (fire) pc_f <= pc_f + 32'd4;
    end
  end

  // Hold buffer parks a response that arrived while decode was stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else if (PCSrc_e || from_hold) begin
      hold_valid <= 1'b0;
    end else if (to_hold) begin
      hold_valid <= 1'b1;
      hold_instr <= IMemRData;
      hold_pc    <= inflight_pc;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (Stall_d),
    .flush      (Flush_d),
    .load       (load),
    .load_instr (load_instr),
    .load_pc    (load_pc),
    .instr      (Instr_d),
    .pc         (PC_d),
    .pc_plus4   (PCPlus4_d),
    .valid      (Valid_d)
  );

`ifdef FETCH_PERF_EN
  logic drop;
  assign drop = (state == WAIT) && IMemRValid && (kill || PCSrc_e);

  // Wrapping counters of delivered instructions and discarded responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FetchCount <= '0;
      KillCount  <= '0;
    end else begin
      if (load && !Flush_d) FetchCount <= FetchCount + 32'd1;
      if (drop) KillCount <= KillCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Stall_f, Stall_d, Flush_d, PCSrc_e;
  logic [31:0] PCTarget_e;
  logic        IMemReq_f;
  logic [31:0] IMemAddr_f;
  logic        IMemGnt_f, IMemRValid;
  logic [31:0] IMemRData;
  logic [31:0] Instr_d, PC_d, PCPlus4_d;
  logic        Valid_d;
`ifdef FETCH_PERF_EN
  logic [31:0] FetchCount, KillCount;
`endif

  int          checks = 0;
  int          failures = 0;

  bit          mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0;
  int          wait_cyc = 0;
  logic        obs_req;
  logic [31:0] obs_addr;
  logic        granted;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Stall_f    (Stall_f),
    .Stall_d    (Stall_d),
    .Flush_d    (Flush_d),
    .PCSrc_e    (PCSrc_e),
    .PCTarget_e (PCTarget_e),
    .IMemReq_f  (IMemReq_f),
    .IMemAddr_f (IMemAddr_f),
    .IMemGnt_f  (IMemGnt_f),
    .IMemRValid (IMemRValid),
    .IMemRData  (IMemRData),
    .Instr_d    (Instr_d),
    .PC_d       (PC_d),
    .PCPlus4_d  (PCPlus4_d),
    .Valid_d    (Valid_d)
`ifdef FETCH_PERF_EN
    ,
    .FetchCount (FetchCount),
    .KillCount  (KillCount)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'b0, Valid_d}, {31'b0, v});
    if (v) begin
      chk({tag, ".pc"}, PC_d, pc);
      chk({tag, ".pc4"}, PCPlus4_d, pc + 32'd4);
      chk({tag, ".instr"}, Instr_d, 32'hAAAA_0000 | pc);
    end else begin
      chk({tag, ".nop"}, Instr_d, NOP);
    end
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
    chk({tag, ".req"}, {31'b0, obs_req}, {31'b0, r});
    if (r) chk({tag, ".addr"}, obs_addr, a);
  endtask

  // One clock cycle starting at a falling edge: zero-or-more-wait memory
  // answering 32'hAAAA_0000 | addr, one outstanding request at a time.
  task automatic cyc();
    IMemRValid = mem_pend && (mem_cnt == 0);
    IMemRData  = IMemRValid ? (32'hAAAA_0000 | mem_addr) : 32'h0;
    #1;
    IMemGnt_f = IMemReq_f && (!mem_pend || IMemRValid);
    #1;
    obs_req  = IMemReq_f;
    obs_addr = IMemAddr_f;
    granted  = IMemReq_f && IMemGnt_f;
    @(posedge clk);
    if (IMemRValid) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (granted) begin
      mem_pend = 1'b1;
      mem_addr = obs_addr;
      mem_cnt  = wait_cyc;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; Stall_f = 1'b0; Stall_d = 1'b0; Flush_d = 1'b0;
    PCSrc_e = 1'b0; PCTarget_e = '0;
    IMemGnt_f = 1'b0; IMemRValid = 1'b0; IMemRData = '0;
    repeat (2) @(negedge clk);
    chk("rst.valid", {31'b0, Valid_d}, 32'd0);
    chk("rst.instr", Instr_d, NOP);
    chk("rst.pc", PC_d, 32'd0);
    chk("rst.pc4", PCPlus4_d, 32'd0);
    chk("rst.req", {31'b0, IMemReq_f}, 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst.fcnt", FetchCount, 32'd0);
    chk("rst.kcnt", KillCount, 32'd0);
`endif
    rst_n = 1'b1;

    // zero-wait streaming from RESET_PC
    cyc(); chk_req("c1", 1'b0, 32'h0);  chk_out("c1", 1'b0, 32'h0);
    cyc(); chk_req("c2", 1'b1, 32'h0);  chk_out("c2", 1'b0, 32'h0);
    cyc(); chk_req("c3", 1'b1, 32'h4);  chk_out("c3", 1'b1, 32'h0);
    cyc(); chk_out("c4", 1'b1, 32'h4);
    cyc(); chk_out("c5", 1'b1, 32'h8);

    // stall with a response in flight: parked in the hold buffer
    Stall_f = 1'b1; Stall_d = 1'b1;
    cyc(); chk_req("c6", 1'b0, 32'h0);  chk_out("c6", 1'b1, 32'h8);
    cyc(); chk_req("c7", 1'b0, 32'h0);  chk_out("c7", 1'b1, 32'h8);
    cyc(); chk_req("c8", 1'b0, 32'h0);  chk_out("c8", 1'b1, 32'h8);
    Stall_f = 1'b0; Stall_d = 1'b0;
    cyc(); chk_req("c9", 1'b0, 32'h0);  chk_out("c9", 1'b1, 32'hC);
    cyc(); chk_req("c10", 1'b1, 32'h10); chk_out("c10", 1'b0, 32'h0);
    cyc(); chk_req("c11", 1'b1, 32'h14); chk_out("c11", 1'b1, 32'h10);

    // redirect while waiting on a 3-wait response: it must be killed
    wait_cyc = 3;
    cyc(); chk_req("c12", 1'b1, 32'h18); chk_out("c12", 1'b1, 32'h14);
    PCSrc_e = 1'b1; PCTarget_e = 32'h100;
    cyc(); chk_req("c13", 1'b0, 32'h0);  chk_out("c13", 1'b0, 32'h0);
    PCSrc_e = 1'b0;
    cyc(); chk_out("c14", 1'b0, 32'h0);
    cyc(); chk_out("c15", 1'b0, 32'h0);
    cyc(); chk_req("c16", 1'b0, 32'h0);  chk_out("c16", 1'b0, 32'h0);
`ifdef FETCH_PERF_EN
    chk("c16.kcnt", KillCount, 32'd1);
`endif
    cyc(); chk_req("c17", 1'b1, 32'h100); chk_out("c17", 1'b0, 32'h0);
    cyc(); chk_out("c18", 1'b0, 32'h0);
    cyc(); chk_out("c19", 1'b0, 32'h0);
    cyc(); chk_out("c20", 1'b0, 32'h0);
    cyc(); chk_req("c21", 1'b1, 32'h104); chk_out("c21", 1'b1, 32'h100);
    cyc(); chk_out("c22", 1'b0, 32'h0);
    cyc(); chk_out("c23", 1'b0, 32'h0);
    cyc(); chk_out("c24", 1'b0, 32'h0);
    cyc(); chk_req("c25", 1'b1, 32'h108); chk_out("c25", 1'b1, 32'h104);
    wait_cyc = 0;
    cyc(); chk_out("c26", 1'b0, 32'h0);
    cyc(); chk_out("c27", 1'b0, 32'h0);
    cyc(); chk_out("c28", 1'b0, 32'h0);
    cyc(); chk_out("c29", 1'b1, 32'h108);
    cyc(); chk_out("c30", 1'b1, 32'h10C);

    // redirect coinciding with a response
    PCSrc_e = 1'b1; PCTarget_e = 32'h200;
    cyc(); chk_req("c31", 1'b0, 32'h0);  chk_out("c31", 1'b0, 32'h0);
    PCSrc_e = 1'b0;
`ifdef FETCH_PERF_EN
    chk("c31.kcnt", KillCount, 32'd2);
`endif
    cyc(); chk_req("c32", 1'b1, 32'h200); chk_out("c32", 1'b0, 32'h0);
    cyc(); chk_out("c33", 1'b1, 32'h200);
`ifdef FETCH_PERF_EN
    chk("c33.fcnt", FetchCount, 32'd11);
`endif

    // flush overrides stall; the arriving response is still held
    Flush_d = 1'b1; Stall_d = 1'b1; Stall_f = 1'b1;
    cyc(); chk_req("c34", 1'b0, 32'h0);  chk_out("c34", 1'b0, 32'h0);
    Flush_d = 1'b0; Stall_d = 1'b0; Stall_f = 1'b0;
    cyc(); chk_out("c35", 1'b1, 32'h204);
    wait_cyc = 3;
    cyc(); chk_req("c36", 1'b1, 32'h208); chk_out("c36", 1'b0, 32'h0);
    cyc(); chk_out("c37", 1'b0, 32'h0);

    // reset mid-WAIT, then a stale response arrives while in REQ
    rst_n = 1'b0;
    cyc(); chk_req("c38", 1'b0, 32'h0);  chk_out("c38", 1'b0, 32'h0);
    chk("c38.pc", PC_d, 32'h0);
    rst_n = 1'b1; wait_cyc = 0;
    cyc(); chk_req("c39", 1'b0, 32'h0);  chk_out("c39", 1'b0, 32'h0);
    cyc(); chk_req("c40", 1'b1, 32'h0);  chk_out("c40", 1'b0, 32'h0);
    cyc(); chk_req("c41", 1'b1, 32'h4);  chk_out("c41", 1'b1, 32'h0);
`ifdef FETCH_PERF_EN
    chk("c41.kcnt", KillCount, 32'd0);
`endif

    // PC wrap at the top of the address space
    PCSrc_e = 1'b1; PCTarget_e = 32'hFFFF_FFFC;
    cyc(); chk_out("c42", 1'b0, 32'h0);
    PCSrc_e = 1'b0;
    cyc(); chk_req("c43", 1'b1, 32'hFFFF_FFFC); chk_out("c43", 1'b0, 32'h0);
    cyc(); chk_req("c44", 1'b1, 32'h0);  chk_out("c44", 1'b1, 32'hFFFF_FFFC);
    cyc(); chk_out("c45", 1'b1, 32'h0);
`ifdef FETCH_PERF_EN
    chk("c45.fcnt", FetchCount, 32'd3);
    chk("c45.kcnt", KillCount, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
